// File: rtl/uart_host_initiator.sv
`default_nettype none
// ============================================================================
// uart_host_initiator
//   Host end of the TPU UART command protocol. It sends a command byte plus up
//   to 7 payload bytes (8N1), then collects up to 4 response bytes into a word.
// Revision: 1.0  initial release
// ============================================================================
module uart_host_initiator #(
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [2:0]  req_len,
    input  logic [55:0] req_payload,
    input  logic [2:0]  req_resp_len,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_timeout,
    output logic        resp_frame_err,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TMO_CYCLES   = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int TMO_W        = $clog2(TMO_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_CMD  = 3'd1,
        S_SEND_PAY  = 3'd2,
        S_RESP_WAIT = 3'd3,
        S_RESP_RX   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       len_q, eff_q, byte_q, nb_q;
    logic [55:0]      payload_q;
    logic [9:0]       tx_shift_q;
    logic             uart_tx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_q;
    logic [1:0]       sync_q;
    logic             rx_prev_q, pend_q;
    logic [7:0]       rx_byte_q;
    logic [31:0]      rx_word_q;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_flag_q, ferr_flag_q;
    logic             resp_valid_q, resp_timeout_q, resp_frame_err_q;
    logic [31:0]      resp_data_q;

    logic       w_rx, w_fall, w_bit_end, w_byte_end, w_more, w_tmo_hit, w_start_ok, w_stop_tick;
    logic [2:0] w_next_idx;
    logic [7:0] w_next_byte;
    state_t     w_after_tx;

    assign w_rx        = sync_q[1];
    assign w_fall      = rx_prev_q & ~w_rx;
    assign w_bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign w_byte_end  = w_bit_end && (bit_q == 4'd9);
    assign w_next_idx  = (state_q == S_SEND_CMD) ? 3'd0 : byte_q + 3'd1;
    assign w_more      = (w_next_idx < len_q);
    assign w_next_byte = payload_q[{w_next_idx, 3'b000} +: 8];
    assign w_after_tx  = (eff_q != 3'd0) ? S_RESP_WAIT : S_DONE;
    // DONE costs one cycle, so expiring one early puts resp_valid TMO_CYCLES after entry
    assign w_tmo_hit   = (tmo_q == TMO_W'(TMO_CYCLES - 2));
    assign w_start_ok  = pend_q && (cnt_q == CNT_W'(HALF_BIT - 1)) && !w_rx;
    assign w_stop_tick = w_bit_end && (bit_q == 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req_valid) state_d = S_SEND_CMD;
            S_SEND_CMD:  if (w_byte_end) state_d = (len_q != 3'd0) ? S_SEND_PAY : w_after_tx;
            S_SEND_PAY:  if (w_byte_end && !w_more) state_d = w_after_tx;
            S_RESP_WAIT: begin
                if (w_tmo_hit)       state_d = S_DONE;
                else if (w_start_ok) state_d = S_RESP_RX;
            end
            S_RESP_RX:   if (w_stop_tick)
                             state_d = (!w_rx || (nb_q + 3'd1 == eff_q)) ? S_DONE : S_RESP_WAIT;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;  eff_q <= '0;  byte_q <= '0;  nb_q <= '0;
            payload_q <= '0;  tx_shift_q <= '1;  uart_tx_q <= 1'b1;
            cnt_q <= '0;  bit_q <= '0;  sync_q <= 2'b11;  rx_prev_q <= 1'b1;
            pend_q <= 1'b0;  rx_byte_q <= '0;  rx_word_q <= '0;  tmo_q <= '0;
            tmo_flag_q <= 1'b0;  ferr_flag_q <= 1'b0;
            resp_valid_q <= 1'b0;  resp_timeout_q <= 1'b0;  resp_frame_err_q <= 1'b0;
            resp_data_q <= '0;
        end else begin
            sync_q       <= {sync_q[0], uart_rx};
            rx_prev_q    <= w_rx;
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    len_q       <= req_len;
                    eff_q       <= (req_resp_len > 3'd4) ? 3'd4 : req_resp_len;
                    payload_q   <= req_payload;
                    tx_shift_q  <= {1'b1, req_cmd, 1'b0};
                    uart_tx_q   <= 1'b0;
                    cnt_q       <= '0;
                    bit_q       <= '0;
                    byte_q      <= '0;
                    nb_q        <= '0;
                    rx_word_q   <= '0;
                    tmo_flag_q  <= 1'b0;
                    ferr_flag_q <= 1'b0;
                    resp_data_q <= '0;
                end
                S_SEND_CMD, S_SEND_PAY: begin
                    if (w_bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 4'd9) begin
                            if (w_more) begin
                                tx_shift_q <= {1'b1, w_next_byte, 1'b0};
                                byte_q     <= w_next_idx;
                                bit_q      <= '0;
                                uart_tx_q  <= 1'b0;
                            end else begin
                                uart_tx_q  <= 1'b1;
                            end
                        end else begin
                            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                            uart_tx_q  <= tx_shift_q[1];
                            bit_q      <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP_WAIT: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (w_tmo_hit) tmo_flag_q <= 1'b1;
                    if (!pend_q) begin
                        if (w_fall) begin
                            pend_q <= 1'b1;
                            cnt_q  <= '0;
                        end
                    end else if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                        pend_q <= 1'b0;
                        cnt_q  <= '0;
                        bit_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP_RX: begin
                    if (w_bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 4'd8) begin
                            // a byte with a bad stop bit is still reported
                            rx_word_q[{nb_q[1:0], 3'b000} +: 8] <= rx_byte_q;
                            nb_q <= nb_q + 3'd1;
                            if (!w_rx) ferr_flag_q <= 1'b1;
                        end else begin
                            rx_byte_q <= {w_rx, rx_byte_q[7:1]};
                            bit_q     <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    resp_valid_q     <= 1'b1;
                    resp_data_q      <= rx_word_q;
                    resp_timeout_q   <= tmo_flag_q;
                    resp_frame_err_q <= ferr_flag_q;
                end
                default: ;
            endcase
            if (state_d == S_RESP_WAIT && state_q != S_RESP_WAIT) begin
                tmo_q  <= '0;
                pend_q <= 1'b0;
            end
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign uart_tx        = uart_tx_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_timeout   = resp_timeout_q;
    assign resp_frame_err = resp_frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_host_initiator.sv
`default_nettype none
// ============================================================================
// tb_uart_host_initiator
//   Directed plus randomized bench for uart_host_initiator with a line-level
//   UART model on both wires. Revision: 1.0
// ============================================================================
module tb_uart_host_initiator;

    localparam int CPB = 10;
    localparam int TMO = 20 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = '0;
    logic [2:0]  req_len = '0;
    logic [55:0] req_payload = '0;
    logic [2:0]  req_resp_len = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        resp_frame_err;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
    logic        busy;

    uart_host_initiator #(
        .CLOCK_FREQ  (1_000_000),
        .BAUD_RATE   (100_000),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_len       (req_len),
        .req_payload   (req_payload),
        .req_resp_len  (req_resp_len),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_timeout  (resp_timeout),
        .resp_frame_err(resp_frame_err),
        .uart_tx       (uart_tx),
        .uart_rx       (uart_rx),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_count = 0, acc_cyc = 0;
    int rv_count = 0, rv_cyc = 0;
    logic [31:0] rv_data;
    logic        rv_to, rv_fe;
    logic [7:0]  mon_q[$];
    logic [7:0]  mb;
    int          mon_bad_stop = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && req_valid && req_ready) begin
            acc_count = acc_count + 1;
            acc_cyc   = cyc;
        end
    end

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            rv_count = rv_count + 1;
            rv_cyc   = cyc;
            rv_data  = resp_data;
            rv_to    = resp_timeout;
            rv_fe    = resp_frame_err;
        end
    end

    // line receiver on uart_tx: detect start, then sample every bit-time
    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mb[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (uart_tx !== 1'b1) mon_bad_stop = mon_bad_stop + 1;
                mon_q.push_back(mb);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp)
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        while (acc_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("accept_seen", 64'(acc_count >= target), 64'd1);
    endtask

    task automatic wait_rv(input int target, input int budget);
        int n;
        n = 0;
        while (rv_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", 64'(rv_count >= target), 64'd1);
    endtask

    task automatic issue(input logic [7:0] c, input logic [2:0] l,
                         input logic [55:0] p, input logic [2:0] rl);
        int s;
        @(negedge clk);
        req_cmd = c; req_len = l; req_payload = p; req_resp_len = rl;
        req_valid = 1'b1;
        s = acc_count;
        wait_acc(s + 1, 3000);
        req_valid = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic check_tx(input string tag, input logic [7:0] c,
                            input logic [2:0] l, input logic [55:0] p);
        chk({tag, "_txcount"}, 64'(mon_q.size()), 64'(1 + int'(l)));
        if (mon_q.size() == 1 + int'(l)) begin
            chk({tag, "_txcmd"}, 64'(mon_q[0]), 64'(c));
            for (int k = 0; k < int'(l); k++)
                chk({tag, "_txpay"}, 64'(mon_q[k + 1]), 64'((p >> (8 * k)) & 56'hFF));
        end
        mon_q.delete();
    endtask

    // reference transaction: random frame, response of n_send bytes out of
    // min(rl,4) expected; missing bytes must end in a timeout
    task automatic run_random();
        logic [7:0]  c;
        logic [2:0]  l, rl;
        logic [55:0] p;
        logic [7:0]  rb[4];
        int eff, nsend, srv, a;
        logic [31:0] exp_data;
        c  = 8'($urandom);
        l  = 3'($urandom_range(0, 7));
        rl = 3'($urandom_range(0, 7));
        p  = {24'($urandom), 32'($urandom)};
        eff = (rl > 3'd4) ? 4 : int'(rl);
        nsend = ($urandom_range(0, 3) == 0 && eff > 0) ? int'($urandom_range(0, eff - 1)) : eff;
        exp_data = '0;
        for (int i = 0; i < 4; i++) begin
            rb[i] = 8'($urandom);
            if (i < nsend) exp_data = exp_data | (32'(rb[i]) << (8 * i));
        end
        srv = rv_count;
        issue(c, l, p, rl);
        a = acc_cyc;
        if (eff > 0) begin
            repeat (100 * (1 + int'(l)) + int'($urandom_range(2, 40))) @(negedge clk);
            for (int i = 0; i < nsend; i++) begin
                drive_byte(rb[i], 1'b1);
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        wait_rv(srv + 1, 3000);
        repeat (5) @(negedge clk);
        chk("rnd_pulses", 64'(rv_count - srv), 64'd1);
        chk("rnd_data", 64'(rv_data), 64'(exp_data));
        chk("rnd_timeout", 64'(rv_to), 64'(nsend < eff));
        chk("rnd_frame_err", 64'(rv_fe), 64'd0);
        if (eff == 0) chk("rnd_latency", 64'(rv_cyc - a), 64'(100 * (1 + int'(l)) + 1));
        check_tx("rnd", c, l, p);
    endtask

    initial begin : stimulus
        int srv, a1, a2, r1, s;
        logic [55:0] p;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 64'(uart_tx), 64'd1);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_flags", 64'({resp_timeout, resp_frame_err}), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: command + 2 payload bytes, no response
        srv = rv_count;
        issue(8'h01, 3'd2, 56'hBEEF, 3'd0);
        a1 = acc_cyc;
        chk("t1_busy", 64'(busy), 64'd1);
        wait_rv(srv + 1, 1000);
        chk("t1_latency", 64'(rv_cyc - a1), 64'd301);
        chk("t1_data", 64'(rv_data), 64'd0);
        chk("t1_flags", 64'({rv_to, rv_fe}), 64'd0);
        repeat (3) @(negedge clk);
        check_tx("t1", 8'h01, 3'd2, 56'hBEEF);

        // 2: four response bytes, little-endian packing
        srv = rv_count;
        issue(8'h05, 3'd0, 56'h0, 3'd4);
        repeat (105) @(negedge clk);
        drive_byte(8'h78, 1'b1);
        drive_byte(8'h56, 1'b1);
        drive_byte(8'h34, 1'b1);
        drive_byte(8'h12, 1'b1);
        wait_rv(srv + 1, 1000);
        chk("t2_data", 64'(rv_data), 64'h12345678);
        chk("t2_flags", 64'({rv_to, rv_fe}), 64'd0);
        check_tx("t2", 8'h05, 3'd0, 56'h0);

        // 3: silent line -> timeout TMO cycles after response wait begins
        srv = rv_count;
        issue(8'h33, 3'd0, 56'h0, 3'd2);
        a1 = acc_cyc;
        wait_rv(srv + 1, 1000);
        chk("t3_latency", 64'(rv_cyc - a1), 64'(100 + TMO));
        chk("t3_timeout", 64'(rv_to), 64'd1);
        chk("t3_frame_err", 64'(rv_fe), 64'd0);
        chk("t3_data", 64'(rv_data), 64'd0);
        mon_q.delete();

        // 4: short glitch ignored, then byte with a bad stop bit
        srv = rv_count;
        issue(8'h44, 3'd0, 56'h0, 3'd1);
        repeat (105) @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12) @(negedge clk);
        drive_byte(8'hA5, 1'b0);
        wait_rv(srv + 1, 1000);
        chk("t4_frame_err", 64'(rv_fe), 64'd1);
        chk("t4_timeout", 64'(rv_to), 64'd0);
        chk("t4_data", 64'(rv_data), 64'h000000A5);
        mon_q.delete();

        // 5: reset in the middle of payload byte 1
        srv = rv_count;
        p = {24'($urandom), 32'($urandom)};
        issue(8'h99, 3'd2, p, 3'd0);
        repeat (250) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_uart_tx", 64'(uart_tx), 64'd1);
        chk("t5_req_ready", 64'(req_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("t5_no_resp", 64'(rv_count - srv), 64'd0);
        mon_q.delete();
        srv = rv_count;
        issue(8'h01, 3'd2, 56'hBEEF, 3'd0);
        a1 = acc_cyc;
        wait_rv(srv + 1, 1000);
        chk("t5_after_latency", 64'(rv_cyc - a1), 64'd301);
        repeat (3) @(negedge clk);
        check_tx("t5", 8'h01, 3'd2, 56'hBEEF);

        // 6: back-to-back with req_valid held high
        srv = rv_count;
        s = acc_count;
        @(negedge clk);
        req_cmd = 8'hA1; req_len = 3'd1; req_payload = 56'h5A; req_resp_len = 3'd0;
        req_valid = 1'b1;
        wait_acc(s + 1, 100);
        a1 = acc_cyc;
        req_cmd = 8'hB2; req_len = 3'd0; req_payload = 56'hFF_FFFF; req_resp_len = 3'd0;
        wait_acc(s + 2, 1000);
        a2 = acc_cyc;
        r1 = rv_cyc;
        req_valid = 1'b0;
        chk("t6_first_latency", 64'(r1 - a1), 64'd201);
        chk("t6_gap", 64'(a2 - r1), 64'd1);
        wait_rv(srv + 2, 1000);
        chk("t6_second_latency", 64'(rv_cyc - a2), 64'd101);
        repeat (3) @(negedge clk);
        chk("t6_txcount", 64'(mon_q.size()), 64'd3);
        if (mon_q.size() == 3) begin
            chk("t6_tx0", 64'(mon_q[0]), 64'hA1);
            chk("t6_tx1", 64'(mon_q[1]), 64'h5A);
            chk("t6_tx2", 64'(mon_q[2]), 64'hB2);
        end
        mon_q.delete();

        // randomized transactions against the reference model
        for (int t = 0; t < 8; t++) run_random();

        chk("tx_stop_bits", 64'(mon_bad_stop), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
